// File: rtl/pow2_stream_averager_pkg.sv
// pow2_avg_pkg: shared types, widths and helpers for the power-of-two stream averager
package pow2_avg_pkg;
    localparam int DEF_DATA_W    = 14;
    localparam int DEF_MAX_LOG2N = 16;
    localparam int ACC_W         = DEF_DATA_W + DEF_MAX_LOG2N;
    typedef enum logic {ACC, OUT} state_t;
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction
endpackage

// File: rtl/pow2_stream_averager_if.sv
// pow2_stream_averager_if: valid/ready stream bundle used on both sides of the averager
interface pow2_stream_averager_if #(parameter int W = 14);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    modport master(output tdata, output tvalid, input tready);
    modport slave(input tdata, input tvalid, output tready);
endinterface

// File: rtl/pow2_stream_averager_decode.sv
// pow2_decode: clamps the requested log2 frame length and expands it to 2^k
module pow2_decode
    import pow2_avg_pkg::*;
#(
    parameter int LOG2N_W   = 8,
    parameter int MAX_LOG2N = DEF_MAX_LOG2N,
    parameter int K_W       = 5
) (
    input  logic [LOG2N_W-1:0] log2n,
    output logic [K_W-1:0]     k,
    output logic [31:0]        n
);
    assign k = log2n > LOG2N_W'(MAX_LOG2N) ? K_W'(MAX_LOG2N) : K_W'(log2n);
    assign n = 32'd1 << k;
endmodule

// File: rtl/pow2_stream_averager.sv
// pow2_stream_averager: accumulates 2^k signed samples and emits their (rounded) mean
module pow2_stream_averager
    import pow2_avg_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_LOG2N = DEF_MAX_LOG2N,
    parameter int LOG2N_W   = 8,
    parameter int ROUND     = 1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [LOG2N_W-1:0]     log2n,
    pow2_stream_averager_if.slave  s_axis,
    pow2_stream_averager_if.master m_axis,
    output logic [31:0]            n_samples,
    output logic                   frame_busy
);
    localparam int AW    = DATA_W + MAX_LOG2N;
    localparam int K_W   = clog2(MAX_LOG2N + 1) > 0 ? clog2(MAX_LOG2N + 1) : 1;
    localparam int CNT_W = MAX_LOG2N > 0 ? MAX_LOG2N : 1;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic signed [AW-1:0]    acc;
    logic [K_W-1:0]          k_dec, k_q, k_eff;
    logic [31:0]             n_dec, n_q, n_eff;
    logic                    last, accept, mv;
    logic [DATA_W-1:0]       md, res;
    logic signed [AW-1:0]    sum, rnd, rsum;

    pow2_decode #(.LOG2N_W(LOG2N_W), .MAX_LOG2N(MAX_LOG2N), .K_W(K_W)) u_decode (
        .log2n(log2n),
        .k    (k_dec),
        .n    (n_dec)
    );

    assign s_axis.tready = aresetn && state == ACC;
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign m_axis.tdata  = md;
    assign m_axis.tvalid = mv;
    assign n_samples     = n_q;
    assign frame_busy    = cnt != '0;

    // The first sample of a frame uses the live decode; later samples use the latched k
    always_comb begin
        k_eff = cnt == '0 ? k_dec : k_q;
        n_eff = cnt == '0 ? n_dec : n_q;
        last  = 32'(cnt) == n_eff - 32'd1;
        sum   = acc + {{MAX_LOG2N{s_axis.tdata[DATA_W-1]}}, s_axis.tdata};
        rnd   = (ROUND != 0 && k_eff != '0) ? AW'(1) << (k_eff - K_W'(1)) : '0;
        rsum  = sum + rnd;
        res   = DATA_W'(rsum >>> k_eff);
    end

    // Frame accumulation and output handshake
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= ACC;
            cnt   <= '0;
            acc   <= '0;
            mv    <= 1'b0;
            md    <= '0;
            k_q   <= '0;
            n_q   <= 32'd1;
        end else if (state == ACC) begin
            if (accept) begin
                if (cnt == '0) begin
                    k_q <= k_dec;
                    n_q <= n_dec;
                end
                if (last) begin
                    acc   <= '0;
                    cnt   <= '0;
                    md    <= res;
                    mv    <= 1'b1;
                    state <= OUT;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end else if (m_axis.tready) begin
            mv    <= 1'b0;
            state <= ACC;
        end
    end
endmodule
